// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 is the core load/store unit and port 1 is a secondary master (loader/debug).
// Each access is IDLE (arbitrate + latch) -> ISSUE (drive memory) -> RESP (loads only).
// The memory reads on a registered posedge and writes on the negedge of ISSUE.
// Optional feature macro: DATA_MEM_ARB_RR_EN selects round-robin arbitration on contention.
// When it is undefined, arbitration is fixed priority and port 0 wins.

module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Owner/last encode the port index: 0 = port 0, 1 = port 1.
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_any_req;
  logic              w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_accept;

  assign w_any_req = req0 | req1;
  assign w_accept  = (r_state == StIdle) && w_any_req;

  // Winner selection; a lone requester always wins, contention goes to the policy.
`ifdef DATA_MEM_ARB_RR_EN
  always_comb begin
    if (req0 && req1) begin
      w_win = ~r_last;
    end else begin
      w_win = ~req0;
    end
  end
`else
  // last is kept for reset compatibility but plays no part in fixed priority.
  logic w_unused_last;
  assign w_unused_last = r_last;

  always_comb begin
    w_win = ~req0;
  end
`endif

  // Route the winning port's request fields toward the capture registers.
  always_comb begin
    if (w_win) begin
      w_win_we    = we1;
      w_win_addr  = addr1;
      w_win_wdata = wdata1;
    end else begin
      w_win_we    = we0;
      w_win_addr  = addr0;
      w_win_wdata = wdata0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: stores finish after ISSUE, loads need one more cycle for data.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (r_we) begin
          w_state_d = StIdle;
        end else begin
          w_state_d = StResp;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Capture the winner in IDLE; memory-side signals then stay stable through ISSUE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_owner     <= w_win;
      r_last      <= w_win;
      r_we        <= w_win_we;
      r_mem_we    <= w_win_we;
      r_mem_addr  <= w_win_addr;
      r_mem_wdata <= w_win_wdata;
    end else begin
      // Write enable lives for exactly the ISSUE cycle; address/data hold.
      r_mem_we    <= 1'b0;
    end
  end

  // Output decode: pulses are steered to the owner only.
  // A read response still in RESP while RST is high is dropped.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    rdata0  = '0;
    rdata1  = '0;
    unique case (r_state)
      StIssue: begin
        gnt0 = ~r_owner;
        gnt1 = r_owner;
      end
      StResp: begin
        rvalid0 = ~r_owner & ~RST;
        rvalid1 = r_owner & ~RST;
      end
      default: begin
      end
    endcase
    if (rvalid0) begin
      rdata0 = mem_rdata;
    end
    if (rvalid1) begin
      rdata1 = mem_rdata;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vector bench for data_mem_arbiter with a small memory model
// (registered posedge read, negedge write). Expectations for contention follow
// DATA_MEM_ARB_RR_EN when the bench is built with it defined.

module tb_data_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  data_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model, preloaded with A000_0000 + index.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
  end
  always @(negedge CLK) if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
  always @(posedge CLK) mem_rdata <= mem[mem_addr[7:0]];

  typedef struct {
    logic [31:0] rst, r0, w0, a0, d0, r1, w1, a1, d1;
    logic [31:0] g0, g1, v0, v1, rd0, rd1, we, ma, md;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic [31:0] rst, r0, w0, a0, d0, r1, w1, a1, d1,
    input logic [31:0] g0, g1, v0, v1, rd0, rd1, we, ma, md);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.v0 = v0; t.v1 = v1; t.rd0 = rd0; t.rd1 = rd1;
    t.we = we; t.ma = ma; t.md = md;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  int grants[$];
  int gexp;

  initial begin
    RST = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(posedge CLK); #1;

    // rst, r0,w0,a0,d0, r1,w1,a1,d1, | g0,g1,v0,v1, rd0,rd1, we, ma,md
    // Reset held with a pending store request: nothing must happen.
    tv.push_back(v(1, 1,1,7,32'h11, 0,0,0,0,  0,0,0,0, 0,0, 0, 0,0));
    tv.push_back(v(1, 1,1,7,32'h11, 0,0,0,0,  0,0,0,0, 0,0, 0, 0,0));
    // Contention, loads addr 3/4, last=1 -> port 0 first, port 1 next.
    tv.push_back(v(0, 1,0,3,0, 1,0,4,0,  0,0,0,0, 0,0, 0, 0,0));
    tv.push_back(v(0, 1,0,3,0, 1,0,4,0,  1,0,0,0, 0,0, 0, 3,0));
    tv.push_back(v(0, 0,0,0,0, 1,0,4,0,  0,0,1,0, 32'hA000_0003,0, 0, 3,0));
    tv.push_back(v(0, 0,0,0,0, 1,0,4,0,  0,0,0,0, 0,0, 0, 3,0));
    tv.push_back(v(0, 0,0,0,0, 1,0,4,0,  0,1,0,0, 0,0, 0, 4,0));
    tv.push_back(v(0, 0,0,0,0, 0,0,0,0,  0,0,0,1, 0,32'hA000_0004, 0, 4,0));
    // Port 0 store DEADBEEF @5, then load it back.
    tv.push_back(v(0, 1,1,5,32'hDEADBEEF, 0,0,0,0,  0,0,0,0, 0,0, 0, 4,0));
    tv.push_back(v(0, 1,1,5,32'hDEADBEEF, 0,0,0,0,  1,0,0,0, 0,0, 1, 5,32'hDEADBEEF));
    tv.push_back(v(0, 1,0,5,32'hDEADBEEF, 0,0,0,0,  0,0,0,0, 0,0, 0, 5,32'hDEADBEEF));
    tv.push_back(v(0, 1,0,5,32'hDEADBEEF, 0,0,0,0,  1,0,0,0, 0,0, 0, 5,32'hDEADBEEF));
    tv.push_back(v(0, 0,0,0,0, 0,0,0,0,  0,0,1,0, 32'hDEADBEEF,0, 0, 5,32'hDEADBEEF));
    // Port 1 store @FF, port 0 loads it.
    tv.push_back(v(0, 0,0,0,0, 1,1,32'hFF,32'hCAFEF00D,  0,0,0,0, 0,0, 0, 5,32'hDEADBEEF));
    tv.push_back(v(0, 0,0,0,0, 1,1,32'hFF,32'hCAFEF00D,  0,1,0,0, 0,0, 1, 32'hFF,32'hCAFEF00D));
    tv.push_back(v(0, 1,0,32'hFF,0, 0,0,0,0,  0,0,0,0, 0,0, 0, 32'hFF,32'hCAFEF00D));
    tv.push_back(v(0, 1,0,32'hFF,0, 0,0,0,0,  1,0,0,0, 0,0, 0, 32'hFF,0));
    tv.push_back(v(0, 0,0,0,0, 0,0,0,0,  0,0,1,0, 32'hCAFEF00D,0, 0, 32'hFF,0));
    // Port 1 load, RST during RESP: response dropped, IDLE with cleared regs after.
    tv.push_back(v(0, 0,0,0,0, 1,0,4,0,  0,0,0,0, 0,0, 0, 32'hFF,0));
    tv.push_back(v(0, 0,0,0,0, 1,0,4,0,  0,1,0,0, 0,0, 0, 4,0));
    tv.push_back(v(1, 0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0, 0, 4,0));
    tv.push_back(v(0, 1,0,3,0, 0,0,0,0,  0,0,0,0, 0,0, 0, 0,0));
    tv.push_back(v(0, 1,0,3,0, 0,0,0,0,  1,0,0,0, 0,0, 0, 3,0));
    tv.push_back(v(0, 0,0,0,0, 0,0,0,0,  0,0,1,0, 32'hA000_0003,0, 0, 3,0));
    // Port 1 store with RST during ISSUE: the write still lands, no further grant.
    tv.push_back(v(0, 0,0,0,0, 1,1,32'h10,32'h12345678,  0,0,0,0, 0,0, 0, 3,0));
    tv.push_back(v(1, 0,0,0,0, 1,1,32'h10,32'h12345678,  0,1,0,0, 0,0, 1, 32'h10,32'h12345678));
    tv.push_back(v(0, 1,0,32'h10,0, 0,0,0,0,  0,0,0,0, 0,0, 0, 0,0));
    tv.push_back(v(0, 1,0,32'h10,0, 0,0,0,0,  1,0,0,0, 0,0, 0, 32'h10,0));
    tv.push_back(v(0, 0,0,0,0, 0,0,0,0,  0,0,1,0, 32'h12345678,0, 0, 32'h10,0));

    foreach (tv[k]) begin
      cyc = k;
      RST = tv[k].rst[0];
      req0 = tv[k].r0[0]; we0 = tv[k].w0[0]; addr0 = tv[k].a0; wdata0 = tv[k].d0;
      req1 = tv[k].r1[0]; we1 = tv[k].w1[0]; addr1 = tv[k].a1; wdata1 = tv[k].d1;
      #2;
      chk("gnt0", {31'b0, gnt0}, tv[k].g0);
      chk("gnt1", {31'b0, gnt1}, tv[k].g1);
      chk("rvalid0", {31'b0, rvalid0}, tv[k].v0);
      chk("rvalid1", {31'b0, rvalid1}, tv[k].v1);
      chk("rdata0", rdata0, tv[k].rd0);
      chk("rdata1", rdata1, tv[k].rd1);
      chk("mem_we", {31'b0, mem_we}, tv[k].we);
      chk("mem_addr", mem_addr, tv[k].ma);
      chk("mem_wdata", mem_wdata, tv[k].md);
      @(posedge CLK); #1;
    end

    // Continuous loads from both ports: record the grant order over six accesses.
    RST = 1'b1; req0 = 0; req1 = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    req0 = 1; we0 = 0; addr0 = 32'h1; wdata0 = 0;
    req1 = 1; we1 = 0; addr1 = 32'h2; wdata1 = 0;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      cyc = 100 + c;
      #2;
      if (gnt0 && gnt1) chk("gnt_exclusive", 32'd2, 32'd1);
      if (gnt0) grants.push_back(0);
      if (gnt1) grants.push_back(1);
      chk("cont_mem_we", {31'b0, mem_we}, 32'd0);
      if (rvalid0) chk("cont_rdata0", rdata0, 32'hA000_0001);
      if (rvalid1) chk("cont_rdata1", rdata1, 32'hA000_0002);
      @(posedge CLK); #1;
    end
    req0 = 0; req1 = 0;
    chk("cont_grant_count", grants.size(), 32'd6);
    foreach (grants[i]) begin
      cyc = 200 + i;
`ifdef DATA_MEM_ARB_RR_EN
      gexp = i % 2;
`else
      gexp = 0;
`endif
      chk("cont_grant_order", grants[i], gexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
